// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Brief    : Round-robin arbiter sharing one multiplier among NUM_REQ requesters
// Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int N               = 16,
    parameter int FRACTIONAL_BITS = 13,
    parameter int NUM_REQ         = 4,
    parameter int TIMEOUT         = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*N-1:0]   req_a,
    input  logic [NUM_REQ*N-1:0]   req_b,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [N-1:0]           rsp_prod,
    output logic                   rsp_overflow,
    output logic                   rsp_timeout,
    output logic [N-1:0]           m_a,
    output logic [N-1:0]           m_b,
    output logic                   m_poke,
    input  logic [N-1:0]           m_prod,
    input  logic                   m_overflow,
    input  logic                   m_peek,
    output logic                   busy
);

    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_pw    = c_idx_w + 1;
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] c_one = NUM_REQ'(1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("mult_arbiter: NUM_REQ must lie in 2..8");
        end
        if (TIMEOUT < 4) begin : g_bad_timeout
            $error("mult_arbiter: TIMEOUT must be at least 4");
        end
        if (FRACTIONAL_BITS >= N) begin : g_bad_frac
            $error("mult_arbiter: FRACTIONAL_BITS must be below N");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   r_owner;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_found;
    logic [c_idx_w-1:0]   w_winner;
    logic [c_idx_w-1:0]   w_next_ptr;
    logic [c_pw-1:0]      w_sum;

    // First active requester at or after r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + c_pw'(k);
            if (w_sum >= c_pw'(NUM_REQ)) begin
                w_sum = w_sum - c_pw'(NUM_REQ);
            end
            if (!w_found && req[w_sum[c_idx_w-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[c_idx_w-1:0];
            end
        end
        w_next_ptr = (w_winner == c_idx_w'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            grant        <= '0;
            rsp_valid    <= '0;
            rsp_prod     <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
            m_a          <= '0;
            m_b          <= '0;
            m_poke       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            grant     <= '0;
            rsp_valid <= '0;
            m_poke    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        grant   <= c_one << w_winner;
                        m_a     <= req_a[w_winner*N +: N];
                        m_b     <= req_b[w_winner*N +: N];
                        m_poke  <= 1'b1;
                        busy    <= 1'b1;
                        r_owner <= w_winner;
                        r_ptr   <= w_next_ptr;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (m_peek) begin
                        rsp_valid    <= c_one << r_owner;
                        rsp_prod     <= m_prod;
                        rsp_overflow <= m_overflow;
                        rsp_timeout  <= 1'b0;
                        r_state      <= S_DRAIN;
                    end else if (r_cnt == c_cnt_w'(TIMEOUT - 1)) begin
                        rsp_valid    <= c_one << r_owner;
                        rsp_prod     <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_timeout  <= 1'b1;
                        r_state      <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // A long result pulse must finish before the next op can start.
                    if (!m_peek) begin
                        m_a     <= '0;
                        m_b     <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mult_arbiter
// Brief    : Self-checking bench for mult_arbiter with a behavioural multiplier
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int N  = 16;
    localparam int FB = 13;
    localparam int NR = 4;
    localparam int TO = 16;

    logic              clk;
    logic              rstn;
    logic [NR-1:0]     req;
    logic [NR*N-1:0]   req_a;
    logic [NR*N-1:0]   req_b;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     rsp_valid;
    logic [N-1:0]      rsp_prod;
    logic              rsp_overflow;
    logic              rsp_timeout;
    logic [N-1:0]      m_a;
    logic [N-1:0]      m_b;
    logic              m_poke;
    logic [N-1:0]      m_prod = '0;
    logic              m_overflow = 1'b0;
    logic              m_peek = 1'b0;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    int  mult_lat   = 1;
    int  mult_hold  = 1;
    bit  mult_stuck = 1'b0;
    bit  peek_force = 1'b0;
    longint cyc       = 0;
    longint mdl_rise  = -100;
    longint mdl_hold  = 0;
    bit     mdl_stuck = 1'b0;
    int     ref_ptr   = 0;

    mult_arbiter #(.N(N), .FRACTIONAL_BITS(FB), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_a(req_a), .req_b(req_b),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_prod(rsp_prod),
        .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
        .m_a(m_a), .m_b(m_b), .m_poke(m_poke), .m_prod(m_prod),
        .m_overflow(m_overflow), .m_peek(m_peek), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sign-magnitude fixed-point product, saturating; returns {overflow, product}.
    function automatic logic [N:0] fx_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint ma, mb, p;
        logic   s;
        ma = longint'(a[N-2:0]);
        mb = longint'(b[N-2:0]);
        p  = (ma * mb) >>> FB;
        s  = a[N-1] ^ b[N-1];
        if (p > ((longint'(1) << (N-1)) - 1)) return {1'b1, s, {(N-1){1'b1}}};
        return {1'b0, s, p[N-2:0]};
    endfunction

    // Multiplier model: result level rises mult_lat cycles after the poke, for mult_hold cycles.
    always @(posedge clk) begin
        if (m_poke) begin
            mdl_rise  = cyc + mult_lat;
            mdl_hold  = mult_hold;
            mdl_stuck = mult_stuck;
            {m_overflow, m_prod} <= fx_mul(m_a, m_b);
        end
        m_peek <= peek_force | (!mdl_stuck && (cyc + 1 >= mdl_rise) && (cyc + 1 < mdl_rise + mdl_hold));
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (mon_en && rstn) begin
            n_tests++;
            if ((grant != 0 && rsp_valid != 0) || !$onehot0(grant) || !$onehot0(rsp_valid)) begin
                n_fail++;
                $display("FAIL onehot_excl: grant=%b rsp_valid=%b, required one-hot and not both", grant, rsp_valid);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk({nm, ".idle_wait"}, busy, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        repeat (2) tick();
        rstn = 1'b1;
        ref_ptr = 0;
        tick();
    endtask

    task automatic run_op(input string nm, input logic [NR-1:0] rq, input logic [N-1:0] a,
                          input logic [N-1:0] b, input int lat, input int hold, input bit stk,
                          input logic [NR-1:0] eg, input logic [N-1:0] ep, input logic eo,
                          input logic et);
        int n;
        int exp_lat;
        mult_lat   = lat;
        mult_hold  = hold;
        mult_stuck = stk;
        for (int i = 0; i < NR; i++) begin
            req_a[i*N +: N] = eg[i] ? a : N'($urandom);
            req_b[i*N +: N] = eg[i] ? b : N'($urandom);
        end
        req = rq;
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == 0 && n < 40);
        chk({nm, ".grant"}, grant, eg);
        if (grant == 0) begin
            req = '0;
            return;
        end
        chk({nm, ".poke"}, m_poke, 1);
        chk({nm, ".m_a"}, m_a, a);
        chk({nm, ".m_b"}, m_b, b);
        chk({nm, ".busy"}, busy, 1);
        req = '0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) chk({nm, ".poke_pulse"}, m_poke, 0);
        end while (rsp_valid == 0 && n < TO + 10);
        exp_lat = stk ? TO + 1 : lat + 1;
        chk({nm, ".latency"}, n, exp_lat);
        chk({nm, ".rsp_valid"}, rsp_valid, eg);
        chk({nm, ".prod"}, rsp_prod, ep);
        chk({nm, ".ovf"}, rsp_overflow, eo);
        chk({nm, ".tmo"}, rsp_timeout, et);
        chk({nm, ".m_a_held"}, m_a, a);
        tick();
        chk({nm, ".rsp_pulse"}, rsp_valid, 0);
        wait_idle(nm);
        chk({nm, ".m_a_clr"}, m_a, 0);
        chk({nm, ".m_b_clr"}, m_b, 0);
        chk({nm, ".prod_hold"}, rsp_prod, ep);
    endtask

    typedef struct {
        logic [NR-1:0] req;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        int            lat;
        int            hold;
        bit            stk;
        logic [NR-1:0] eg;
        logic [N-1:0]  ep;
        logic          eo;
        logic          et;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int n;
        int pulses;
        int bad;
        logic [NR-1:0] exp_seq [5];
        logic [NR-1:0] rq;
        logic [N-1:0]  ra;
        logic [N-1:0]  rb;
        logic [N:0]    rp;
        int            w;
        bit            stk;

        tbl[0] = '{4'b0001, 16'h2000, 16'h3000, 1, 1, 1'b0, 4'b0001, 16'h3000, 1'b0, 1'b0};
        tbl[1] = '{4'b0001, 16'hA000, 16'h3000, 1, 1, 1'b0, 4'b0001, 16'hB000, 1'b0, 1'b0};
        tbl[2] = '{4'b1001, 16'h6000, 16'h6000, 2, 1, 1'b0, 4'b1000, 16'h7FFF, 1'b1, 1'b0};
        tbl[3] = '{4'b1001, 16'h1000, 16'h9000, 1, 2, 1'b0, 4'b0001, 16'h8800, 1'b0, 1'b0};
        tbl[4] = '{4'b0011, 16'h2000, 16'h0000, 1, 1, 1'b0, 4'b0010, 16'h0000, 1'b0, 1'b0};
        tbl[5] = '{4'b0110, 16'h4000, 16'hC000, 1, 3, 1'b0, 4'b0100, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{4'b0011, 16'h2001, 16'h2000, 3, 2, 1'b0, 4'b0001, 16'h2001, 1'b0, 1'b0};
        tbl[7] = '{4'b1100, 16'h1234, 16'h2222, 1, 1, 1'b1, 4'b0100, 16'h0000, 1'b0, 1'b1};
        tbl[8] = '{4'b1000, 16'h2000, 16'h2000, 1, 1, 1'b0, 4'b1000, 16'h2000, 1'b0, 1'b0};

        rstn  = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) tick();
        chk("rst.grant", grant, 0);
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.m_a", m_a, 0);
        chk("rst.m_poke", m_poke, 0);
        chk("rst.prod", rsp_prod, 0);
        rstn = 1'b1;
        mon_en = 1'b1;
        tick();
        chk("rst.idle_busy", busy, 0);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].lat,
                   tbl[i].hold, tbl[i].stk, tbl[i].eg, tbl[i].ep, tbl[i].eo, tbl[i].et);
        end

        // Result level while idle must not produce a response.
        peek_force = 1'b1;
        bad = 0;
        repeat (5) begin
            tick();
            if (busy || rsp_valid != 0 || grant != 0) bad++;
        end
        peek_force = 1'b0;
        tick();
        chk("idle_peek.ignored", bad, 0);

        do_reset();
        mult_lat = 1; mult_hold = 1; mult_stuck = 1'b0;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_a = {NR{16'h2000}};
        req_b = {NR{16'h3000}};
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (grant == 0 && n < 40);
            chk($sformatf("cont.grant%0d", g), grant, exp_seq[g]);
            chk($sformatf("cont.gap%0d", g), n, (g == 0) ? 1 : 4);
        end
        req = '0;
        wait_idle("cont");
        ref_ptr = 1;

        mult_lat = 1; mult_hold = 3; mult_stuck = 1'b0;
        req = 4'b0001;
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == 0 && n < 40);
        chk("str.grant0", grant, 4'b0001);
        pulses = 0;
        n = 0;
        do begin
            tick();
            n++;
            if (rsp_valid != 0) pulses++;
        end while (grant == 0 && n < 40);
        chk("str.pulses", pulses, 1);
        chk("str.gap", n, 6);
        chk("str.grant1", grant, 4'b0001);
        req = '0;
        wait_idle("str");
        chk("str.prod", rsp_prod, 16'h3000);

        mult_lat = 5; mult_hold = 1; mult_stuck = 1'b0;
        req = 4'b0001;
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == 0 && n < 40);
        chk("rstw.grant", grant, 4'b0001);
        req = '0;
        tick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("rstw.busy", busy, 0);
        chk("rstw.m_a", m_a, 0);
        chk("rstw.m_b", m_b, 0);
        chk("rstw.prod", rsp_prod, 0);
        chk("rstw.flags", {grant, rsp_valid, m_poke, rsp_overflow, rsp_timeout}, 0);
        tick();
        rstn = 1'b1;
        bad = 0;
        repeat (15) begin
            tick();
            if (rsp_valid != 0 || busy || grant != 0) bad++;
        end
        chk("rstw.no_resume", bad, 0);
        ref_ptr = 0;

        for (int t = 0; t < 40; t++) begin
            rq  = NR'($urandom_range(1, (1 << NR) - 1));
            ra  = N'($urandom);
            rb  = N'($urandom);
            stk = ($urandom_range(0, 7) == 0);
            w = -1;
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && rq[(ref_ptr + k) % NR]) w = (ref_ptr + k) % NR;
            end
            ref_ptr = (w + 1) % NR;
            rp = stk ? '0 : fx_mul(ra, rb);
            run_op($sformatf("rnd%0d", t), rq, ra, rb, $urandom_range(1, 4), $urandom_range(1, 3),
                   stk, NR'(1) << w, rp[N-1:0], rp[N], stk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N, default 16, total operand/product width, sign-magnitude (bit N-1 = sign).
REQ-002 Parameter FRACTIONAL_BITS, default 13, fractional bits of operands/product; passed through only, no arithmetic here.
REQ-003 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-004 Parameter TIMEOUT, default 16, max cycles in WAIT before abort (>=4).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low. Ports: clk  input  1  rising-edge clock; rstn  input  1  async active-low reset.
REQ-006 Requester ports: req  input  NUM_REQ  per-requester request level; req_a  input  NUM_REQ*N  operand A, slice i = bits [i*N+N-1:i*N]; req_b  input  NUM_REQ*N  operand B, same slicing.
REQ-007 Response ports: grant  output  NUM_REQ  one-hot, 1-cycle acceptance pulse; rsp_valid  output  NUM_REQ  one-hot, 1-cycle result pulse to owner; rsp_prod  output  N  captured product; rsp_overflow  output  1  captured overflow; rsp_timeout  output  1  op aborted, qualified by rsp_valid.
REQ-008 Multiplier ports: m_a  output  N  operand A; m_b  output  N  operand B; m_poke  output  1  start pulse; m_prod  input  N  product; m_overflow  input  1  overflow; m_peek  input  1  result-ready level.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 FSM states: IDLE, ISSUE, WAIT, DRAIN; all outputs registered.
REQ-011 IDLE: if req != 0, select winner by round-robin; in the next cycle grant[winner]=1, m_a/m_b loaded from winner's slices, owner recorded, state ISSUE; if req == 0, stay IDLE.
REQ-012 Round-robin: search starts at index ptr, wraps modulo NUM_REQ; after a grant to i, ptr = (i+1) mod NUM_REQ; ptr reset value 0.
REQ-013 ISSUE: m_poke=1 for exactly this one cycle; timeout counter cleared; next state WAIT.
REQ-014 WAIT: on first cycle m_peek sampled 1, capture m_prod into rsp_prod and m_overflow into rsp_overflow, rsp_timeout=0, rsp_valid[owner]=1 next cycle, state DRAIN.
REQ-015 WAIT: counter increments each cycle m_peek=0; when it reaches TIMEOUT, rsp_valid[owner]=1 with rsp_timeout=1, rsp_prod=0, rsp_overflow=0, state DRAIN.
REQ-016 DRAIN: stay until m_peek sampled 0, then IDLE; no new grant issued while m_peek=1.
REQ-017 m_a/m_b held constant from grant cycle until the cycle DRAIN exits; zero in IDLE when no op is active.
REQ-018 Latency: with a multiplier raising m_peek the cycle after m_poke, grant at cycle t, m_poke at t, rsp_valid at t+2.
REQ-019 rsp_prod/rsp_overflow/rsp_timeout hold their last captured value until the next capture.
REQ-020 grant and rsp_valid never assert in the same cycle; at most one bit of each is set.
REQ-021 req dropped by a requester before grant: no grant to it; req held after grant is treated as a new request and re-arbitrated in the next IDLE.
REQ-022 Simultaneous requests: exactly one granted per op; others wait, with no starvation (each waits at most NUM_REQ-1 ops).
REQ-023 m_peek=1 while in IDLE or ISSUE is ignored.

Reset
REQ-024 rstn low, at any time including mid-op: state IDLE, ptr=0, owner=0, counter=0; grant, rsp_valid, m_poke, busy, m_a, m_b, rsp_prod, rsp_overflow, rsp_timeout all 0; no pending op is resumed after release.

Verification
REQ-025 Single op: req=0001, a=0x2000 (1.0), b=0x3000 (1.5), ideal mult -> grant=0001, m_poke 1 cycle, rsp_valid=0001 two cycles later, rsp_prod=0x3000, rsp_overflow=0.
REQ-026 Contention: req=1111 held continuously -> grants in order 0001,0010,0100,1000,0001, each grant only after the previous DRAIN exits.
REQ-027 Pointer wrap: grant to requester 3, then req=1001 -> requester 0 granted, ptr=1.
REQ-028 Timeout: multiplier m_peek stuck 0 -> rsp_valid to owner exactly TIMEOUT WAIT cycles after ISSUE, rsp_timeout=1, rsp_prod=0.
REQ-029 Stretched peek: m_peek high 3 cycles -> single rsp_valid pulse; next grant only after m_peek low.
REQ-030 Reset mid-WAIT: rstn pulsed low -> all outputs 0 immediately (async); after release and m_peek arriving, no rsp_valid.
